// File: rtl/decode_pkg.sv
// Shared decode definitions: RV32 opcode constants, immediate-format
// selector and the helpers that classify opcodes and build immediates.
package decode_pkg;

  localparam logic [6:0] OP_R     = 7'b0110011;
  localparam logic [6:0] OP_I     = 7'b0010011;
  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_JALR  = 7'b1100111;
  localparam logic [6:0] OP_S     = 7'b0100011;
  localparam logic [6:0] OP_B     = 7'b1100011;
  localparam logic [6:0] OP_LUI   = 7'b0110111;
  localparam logic [6:0] OP_AUIPC = 7'b0010111;
  localparam logic [6:0] OP_JAL   = 7'b1101111;

  typedef enum logic [2:0] {
    IMM_I,
    IMM_S,
    IMM_B,
    IMM_U,
    IMM_J,
    IMM_NONE
  } imm_t;

  // Immediate format for an opcode; R-type and unknown opcodes carry none.
  function automatic imm_t imm_sel(input logic [6:0] op);
    case (op)
      OP_I, OP_LOAD, OP_JALR: return IMM_I;
      OP_S:                   return IMM_S;
      OP_B:                   return IMM_B;
      OP_LUI, OP_AUIPC:       return IMM_U;
      OP_JAL:                 return IMM_J;
      default:                return IMM_NONE;
    endcase
  endfunction

  // True for every opcode this decoder understands.
  function automatic logic op_known(input logic [6:0] op);
    case (op)
      OP_R, OP_I, OP_LOAD, OP_JALR, OP_S,
      OP_B, OP_LUI, OP_AUIPC, OP_JAL: return 1'b1;
      default:                        return 1'b0;
    endcase
  endfunction

  // 32-bit immediate, already sign-extended from instr[31].
  function automatic logic [31:0] imm_gen(input logic [31:0] ins, input imm_t sel);
    case (sel)
      IMM_I:   return {{20{ins[31]}}, ins[31:20]};
      IMM_S:   return {{20{ins[31]}}, ins[31:25], ins[11:7]};
      IMM_B:   return {{19{ins[31]}}, ins[31], ins[7], ins[30:25], ins[11:8], 1'b0};
      IMM_U:   return {ins[31:12], 12'b0};
      IMM_J:   return {{11{ins[31]}}, ins[31], ins[19:12], ins[20], ins[30:21], 1'b0};
      default: return '0;
    endcase
  endfunction

endpackage

// File: rtl/decode_regfile.sv
// Integer register file: two combinational read ports, one write port,
// x0 hardwired to zero, out-of-range read indices return zero.
module decode_regfile #(
  parameter  int XLEN  = 32,
  parameter  int NREGS = 32,
  localparam int AW    = $clog2(NREGS)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            i_we,
  input  logic [AW-1:0]   i_waddr,
  input  logic [XLEN-1:0] i_wdata,
  input  logic [4:0]      i_raddr1,
  input  logic [4:0]      i_raddr2,
  output logic [XLEN-1:0] o_rdata1,
  output logic [XLEN-1:0] o_rdata2
);

  logic [XLEN-1:0] r_mem [NREGS];
  logic            w_oob1;
  logic            w_oob2;

  // Only the 16-entry file can see an index beyond its range.
  assign w_oob1 = (NREGS == 16) ? i_raddr1[4] : 1'b0;
  assign w_oob2 = (NREGS == 16) ? i_raddr2[4] : 1'b0;

  assign o_rdata1 = (w_oob1 || i_raddr1 == '0) ? '0 : r_mem[i_raddr1[AW-1:0]];
  assign o_rdata2 = (w_oob2 || i_raddr2 == '0) ? '0 : r_mem[i_raddr2[AW-1:0]];

  // Storage: cleared on reset, written by writeback except for x0.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned i = 0; i < NREGS; i++) begin
        r_mem[i] <= '0;
      end
    end else if (i_we && i_waddr != '0) begin
      r_mem[i_waddr] <= i_wdata;
    end
  end

endmodule

// File: rtl/decode_pipe.sv
// Decode stage: register-file read, immediate/branch-offset generation and
// a single registered output slot with valid/ready, flush and stall.
// Define DECODE_BYPASS_EN to forward same-cycle writeback data into the
// captured operands; by default the pre-write register value is captured.
module decode_pipe
  import decode_pkg::*;
#(
  parameter  int XLEN  = 32,
  parameter  int NREGS = 32,
  localparam int AW    = $clog2(NREGS)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [31:0]     instruction,
  input  logic            flush,
  input  logic            w_en,
  input  logic [AW-1:0]   wd,
  input  logic [XLEN-1:0] wdata,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] op1,
  output logic [XLEN-1:0] op2,
  output logic [XLEN-1:0] st,
  output logic [XLEN-1:0] branch_offset,
  output logic [4:0]      rd,
  output logic [6:0]      opcode,
  output logic            illegal
);

  logic            r_valid;
  logic [XLEN-1:0] r_op1;
  logic [XLEN-1:0] r_op2;
  logic [XLEN-1:0] r_st;
  logic [XLEN-1:0] r_bo;
  logic [4:0]      r_rd;
  logic [6:0]      r_opcode;
  logic            r_illegal;

  logic [6:0]      w_op;
  logic [4:0]      w_rs1;
  logic [4:0]      w_rs2;
  logic [XLEN-1:0] w_rf1;
  logic [XLEN-1:0] w_rf2;
  logic [XLEN-1:0] w_src1;
  logic [XLEN-1:0] w_src2;
  logic            w_oob1;
  logic            w_oob2;
  imm_t            w_sel;
  logic [31:0]     w_imm32;
  logic [XLEN-1:0] w_imm;
  logic [XLEN-1:0] w_op2;
  logic [XLEN-1:0] w_bo;
  logic            w_illegal;
  logic            w_capture;

  assign w_op  = instruction[6:0];
  assign w_rs1 = instruction[19:15];
  assign w_rs2 = instruction[24:20];

  decode_regfile #(
    .XLEN  (XLEN),
    .NREGS (NREGS)
  ) u_regfile (
    .clk      (clk),
    .rst      (rst),
    .i_we     (w_en),
    .i_waddr  (wd),
    .i_wdata  (wdata),
    .i_raddr1 (w_rs1),
    .i_raddr2 (w_rs2),
    .o_rdata1 (w_rf1),
    .o_rdata2 (w_rf2)
  );

`ifdef DECODE_BYPASS_EN
  logic [4:0] w_wd5;
  assign w_wd5 = 5'(wd);

  // Forward writeback data onto any operand path reading the same register.
  always_comb begin
    w_src1 = w_rf1;
    w_src2 = w_rf2;
    if (w_en && wd != '0 && w_wd5 == w_rs1) w_src1 = wdata;
    if (w_en && wd != '0 && w_wd5 == w_rs2) w_src2 = wdata;
  end
`else
  assign w_src1 = w_rf1;
  assign w_src2 = w_rf2;
`endif

  assign w_oob1 = (NREGS == 16) ? w_rs1[4] : 1'b0;
  assign w_oob2 = (NREGS == 16) ? w_rs2[4] : 1'b0;

  assign w_sel     = imm_sel(w_op);
  assign w_imm32   = imm_gen(instruction, w_sel);
  assign w_imm     = XLEN'($signed(w_imm32));
  assign w_op2     = (w_op == OP_R || w_op == OP_B) ? w_src2 : w_imm;
  assign w_bo      = (w_sel == IMM_B || w_sel == IMM_J) ? w_imm : '0;
  assign w_illegal = !op_known(w_op) || w_oob1 || w_oob2;

  assign in_ready  = !flush && (!r_valid || out_ready);
  assign w_capture = in_valid && in_ready;

  // Output slot: load on capture; otherwise drain on consume or flush,
  // leaving the data registers untouched so a stall holds them stable.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_valid   <= 1'b0;
      r_op1     <= '0;
      r_op2     <= '0;
      r_st      <= '0;
      r_bo      <= '0;
      r_rd      <= '0;
      r_opcode  <= '0;
      r_illegal <= 1'b0;
    end else if (w_capture) begin
      r_valid   <= 1'b1;
      r_op1     <= w_src1;
      r_op2     <= w_op2;
      r_st      <= w_src2;
      r_bo      <= w_bo;
      r_rd      <= instruction[11:7];
      r_opcode  <= w_op;
      r_illegal <= w_illegal;
    end else if (flush || out_ready) begin
      r_valid   <= 1'b0;
    end
  end

  assign out_valid     = r_valid;
  assign op1           = r_op1;
  assign op2           = r_op2;
  assign st            = r_st;
  assign branch_offset = r_bo;
  assign rd            = r_rd;
  assign opcode        = r_opcode;
  assign illegal       = r_illegal;

endmodule

// File: tb/tb_decode_pipe.sv
// Scoreboard bench for decode_pipe: a 32-register instance for the main
// sequence and a 16-register instance for range checks.
module tb_decode_pipe;

  typedef struct {
    logic [31:0] op1;
    logic [31:0] op2;
    logic [31:0] st;
    logic [31:0] bo;
    logic [4:0]  rd;
    logic [6:0]  opc;
    logic        ill;
  } exp_t;

  logic clk = 1'b0;
  logic rst;

  logic        in_valid, in_ready, flush, w_en, out_valid, out_ready, illegal;
  logic [31:0] instruction, wdata, op1, op2, st, branch_offset;
  logic [4:0]  wd, rd;
  logic [6:0]  opcode;

  logic        in_valid_b, in_ready_b, flush_b, w_en_b, out_valid_b, out_ready_b, illegal_b;
  logic [31:0] instruction_b, wdata_b, op1_b, op2_b, st_b, branch_offset_b;
  logic [3:0]  wd_b;
  logic [4:0]  rd_b;
  logic [6:0]  opcode_b;

  int   n_tests = 0;
  int   n_fail  = 0;
  exp_t qa[$];
  exp_t qb[$];

  always #5 clk = ~clk;

  decode_pipe #(.XLEN(32), .NREGS(32)) u_dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .instruction(instruction), .flush(flush), .w_en(w_en), .wd(wd), .wdata(wdata),
    .out_valid(out_valid), .out_ready(out_ready), .op1(op1), .op2(op2), .st(st),
    .branch_offset(branch_offset), .rd(rd), .opcode(opcode), .illegal(illegal)
  );

  decode_pipe #(.XLEN(32), .NREGS(16)) u_dut16 (
    .clk(clk), .rst(rst), .in_valid(in_valid_b), .in_ready(in_ready_b),
    .instruction(instruction_b), .flush(flush_b), .w_en(w_en_b), .wd(wd_b), .wdata(wdata_b),
    .out_valid(out_valid_b), .out_ready(out_ready_b), .op1(op1_b), .op2(op2_b), .st(st_b),
    .branch_offset(branch_offset_b), .rd(rd_b), .opcode(opcode_b), .illegal(illegal_b)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  function automatic exp_t mk(input logic [31:0] a, input logic [31:0] b, input logic [31:0] s,
                              input logic [31:0] o, input logic [4:0] r, input logic [6:0] c,
                              input logic i);
    exp_t e;
    e.op1 = a; e.op2 = b; e.st = s; e.bo = o; e.rd = r; e.opc = c; e.ill = i;
    return e;
  endfunction

  task automatic cmp(input string tag, input exp_t e, input logic [31:0] a, input logic [31:0] b,
                     input logic [31:0] s, input logic [31:0] o, input logic [4:0] r,
                     input logic [6:0] c, input logic i);
    check({tag, "_op1"}, a, e.op1);
    check({tag, "_op2"}, b, e.op2);
    check({tag, "_st"}, s, e.st);
    check({tag, "_branch_offset"}, o, e.bo);
    check({tag, "_rd"}, 32'(r), 32'(e.rd));
    check({tag, "_opcode"}, 32'(c), 32'(e.opc));
    check({tag, "_illegal"}, 32'(i), 32'(e.ill));
  endtask

  // Monitors: a transfer happens at the next edge when valid && ready.
  always @(negedge clk) begin
    if (!rst && out_valid && out_ready) begin
      if (qa.size() == 0) begin
        n_tests++; n_fail++;
        $display("FAIL a_unexpected_output: got opcode 0x%02h expected no output", opcode);
      end else begin
        exp_t e;
        e = qa.pop_front();
        cmp("a", e, op1, op2, st, branch_offset, rd, opcode, illegal);
      end
    end
  end

  always @(negedge clk) begin
    if (!rst && out_valid_b && out_ready_b) begin
      if (qb.size() == 0) begin
        n_tests++; n_fail++;
        $display("FAIL b_unexpected_output: got opcode 0x%02h expected no output", opcode_b);
      end else begin
        exp_t e;
        e = qb.pop_front();
        cmp("b", e, op1_b, op2_b, st_b, branch_offset_b, rd_b, opcode_b, illegal_b);
      end
    end
  end

  task automatic wr(input bit b16, input logic [4:0] idx, input logic [31:0] val);
    if (b16) begin w_en_b = 1'b1; wd_b = idx[3:0]; wdata_b = val; end
    else     begin w_en   = 1'b1; wd   = idx;      wdata   = val; end
    @(posedge clk); #1;
    w_en = 1'b0; w_en_b = 1'b0;
  endtask

  task automatic issue(input bit b16, input logic [31:0] ins, input bit push, input exp_t e);
    int unsigned n;
    if (push) begin
      if (b16) qb.push_back(e); else qa.push_back(e);
    end
    if (b16) begin in_valid_b = 1'b1; instruction_b = ins; end
    else     begin in_valid   = 1'b1; instruction   = ins; end
    n = 0;
    while (!(b16 ? in_ready_b : in_ready) && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    if (!(b16 ? in_ready_b : in_ready)) begin
      n_tests++; n_fail++;
      $display("FAIL issue_timeout: got in_ready=0 expected 1 for 0x%08h", ins);
    end
    @(posedge clk); #1;
    if (b16) in_valid_b = 1'b0; else in_valid = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    exp_t none;
    logic [31:0] sw_st;
    none = mk(0, 0, 0, 0, 0, 0, 0);
`ifdef DECODE_BYPASS_EN
    sw_st = 32'h0000_00AA;
`else
    sw_st = 32'h0000_0000;
`endif
    in_valid = 0; instruction = 0; flush = 0; w_en = 0; wd = 0; wdata = 0; out_ready = 1;
    in_valid_b = 0; instruction_b = 0; flush_b = 0; w_en_b = 0; wd_b = 0; wdata_b = 0; out_ready_b = 1;
    rst = 1;
    repeat (2) @(posedge clk);
    #1 rst = 0;

    // reset state
    check("rst_out_valid", 32'(out_valid), 0);
    check("rst_in_ready", 32'(in_ready), 1);
    check("rst_op1", op1, 0);
    check("rst_op2", op2, 0);
    check("rst_st", st, 0);
    check("rst_branch_offset", branch_offset, 0);
    check("rst_rd", 32'(rd), 0);
    check("rst_opcode", 32'(opcode), 0);
    check("rst_illegal", 32'(illegal), 0);

    // addi x1,x5,-1
    wr(0, 5, 32'h0000_1234);
    issue(0, 32'hFFF2_8093, 1, mk(32'h1234, 32'hFFFF_FFFF, 0, 0, 1, 7'h13, 0));
    check("addi_latency_valid", 32'(out_valid), 1);
    check("addi_latency_op1", op1, 32'h1234);

    // beq x1,x2,-8 ; add x10,x1,x2 ; jal x1,-4
    wr(0, 1, 32'h11);
    wr(0, 2, 32'h22);
    issue(0, 32'hFE20_8CE3, 1, mk(32'h11, 32'h22, 32'h22, 32'hFFFF_FFF8, 25, 7'h63, 0));
    issue(0, 32'h0020_8533, 1, mk(32'h11, 32'h22, 32'h22, 0, 10, 7'h33, 0));
    issue(0, 32'hFFDF_F0EF, 1, mk(0, 32'hFFFF_FFFC, 0, 32'hFFFF_FFFC, 1, 7'h6F, 0));
    @(posedge clk); #1;

    // stall: lui x4,0x12345 held while addi x6,x0,5 waits; x8 written mid-stall
    out_ready = 0;
    issue(0, 32'h1234_5237, 1, mk(0, 32'h1234_5000, 0, 0, 4, 7'h37, 0));
    in_valid = 1; instruction = 32'h0050_0313;
    qa.push_back(mk(0, 5, 32'h1234, 0, 6, 7'h13, 0));
    w_en = 1; wd = 8; wdata = 32'h99;
    for (int k = 0; k < 3; k++) begin
      check("stall_in_ready", 32'(in_ready), 0);
      check("stall_out_valid", 32'(out_valid), 1);
      check("stall_op1_held", op1, 0);
      check("stall_op2_held", op2, 32'h1234_5000);
      @(posedge clk); #1;
      w_en = 0;
    end
    out_ready = 1;
    @(posedge clk); #1;
    in_valid = 0;
    check("release_capture_rd", 32'(rd), 6);

    // writeback to x3 in the capture cycle of sw x3,0(x0)
    w_en = 1; wd = 3; wdata = 32'hAA;
    issue(0, 32'h0030_2023, 1, mk(0, 0, sw_st, 0, 0, 7'h23, 0));
    w_en = 0;
    issue(0, 32'h0001_85B3, 1, mk(32'hAA, 0, 0, 0, 11, 7'h33, 0));
    @(posedge clk); #1;

    // flush with a held instruction and a new one presented
    out_ready = 0;
    issue(0, 32'h0000_1397, 0, none);
    in_valid = 1; instruction = 32'h0000_0493; flush = 1;
    #1 check("flush_in_ready", 32'(in_ready), 0);
    @(posedge clk); #1;
    check("flush_out_valid", 32'(out_valid), 0);
    check("flush_data_kept", op2, 32'h1000);
    flush = 0; in_valid = 0; out_ready = 1;
    @(posedge clk); #1;
    check("flush_no_capture", 32'(out_valid), 0);

    // write to x0 is ignored; unknown opcode
    wr(0, 0, 32'hDEAD);
    issue(0, 32'h0000_0493, 1, mk(0, 0, 0, 0, 9, 7'h13, 0));
    issue(0, 32'h0000_007F, 1, mk(0, 0, 0, 0, 0, 7'h7F, 1));

    // 16-register instance: out-of-range rs1, in-range, unknown opcode
    wr(1, 2, 32'h55);
    issue(1, 32'h0028_80B3, 1, mk(0, 32'h55, 32'h55, 0, 1, 7'h33, 1));
    issue(1, 32'h0021_00B3, 1, mk(32'h55, 32'h55, 32'h55, 0, 1, 7'h33, 0));
    issue(1, 32'h0000_007F, 1, mk(0, 0, 0, 0, 0, 7'h7F, 1));
    repeat (2) @(posedge clk);
    #1;

    // reset during a stall drops the held instruction
    out_ready = 0;
    issue(0, 32'h0050_0313, 0, none);
    check("pre_reset_valid", 32'(out_valid), 1);
    rst = 1;
    #1 check("async_reset_valid", 32'(out_valid), 0);
    check("async_reset_op2", op2, 0);
    @(posedge clk); #1;
    rst = 0; out_ready = 1;
    repeat (2) @(posedge clk);
    #1 check("post_reset_no_output", 32'(out_valid), 0);
    issue(0, 32'h0001_85B3, 1, mk(0, 0, 0, 0, 11, 7'h33, 0));

    for (int n = 0; n < 20 && (qa.size() != 0 || qb.size() != 0); n++) begin
      @(posedge clk); #1;
    end
    check("qa_drained", 32'(qa.size()), 0);
    check("qb_drained", 32'(qb.size()), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
